// File: rtl/softmax_max_subtract.sv
// softmax_max_subtract: buffers one softmax frame, tracks its maximum, then streams x_i - max.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_valid/i_data: signed Q4.12 input beats, accepted when o_ready is high
//   o_ready       : high while loading a frame
//   o_valid/o_data: signed Q4.12 x_i - max (saturated), contiguous NUM_ELEM-beat burst
//   o_last        : marks the final element of the burst
//   o_max         : registered frame maximum
module softmax_max_subtract #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_ELEM  = 32,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [BIT_WIDTH-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [BIT_WIDTH-1:0] o_data,
  output logic                 o_last,
  output logic [BIT_WIDTH-1:0] o_max
);
  typedef enum logic {LOAD, EMIT} state_t;
  state_t                r_state, w_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [BIT_WIDTH-1:0]  r_max;
  logic [BIT_WIDTH-1:0]  r_buf [NUM_ELEM];
  logic                  w_accept, w_cnt_end;
  logic [BIT_WIDTH-1:0]  w_new_max, w_elem, w_sat;
  logic [BIT_WIDTH:0]    w_diff;
  assign o_ready   = r_state == LOAD;
  assign w_accept  = i_valid && o_ready;
  assign w_cnt_end = r_cnt == CNT_WIDTH'(NUM_ELEM - 1);
  assign w_new_max = (r_cnt == '0 || $signed(i_data) > $signed(r_max)) ? i_data : r_max;
  assign w_elem    = r_buf[r_cnt];
  assign w_diff    = {w_elem[BIT_WIDTH-1], w_elem} - {r_max[BIT_WIDTH-1], r_max};
  // The difference is never positive, so only the negative overflow needs clamping.
  assign w_sat     = (w_diff[BIT_WIDTH] && !w_diff[BIT_WIDTH-1]) ?
                     {1'b1, {(BIT_WIDTH-1){1'b0}}} : w_diff[BIT_WIDTH-1:0];
  always_comb begin
    w_next = r_state;
    w_next = (r_state == LOAD) ? ((w_accept && w_cnt_end) ? EMIT : LOAD)
                               : (w_cnt_end ? LOAD : EMIT);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= LOAD;
    else       r_state <= w_next;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_max   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= '0;
      o_max   <= '0;
    end else begin
      o_valid <= r_state == EMIT;
      o_last  <= r_state == EMIT && w_cnt_end;
      if (r_state == EMIT || w_accept) r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
      if (r_state == EMIT) o_data <= w_sat;
      if (w_accept) r_max <= w_new_max;
      if (w_accept && w_cnt_end) o_max <= w_new_max;
    end
  end
  // Sample storage carries no reset; every slot is rewritten before it is read.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_buf[r_cnt] <= i_data;
  end
endmodule

// File: tb/tb_softmax_max_subtract.sv
// tb_softmax_max_subtract: table-driven, scoreboarded bench for softmax_max_subtract.
module tb_softmax_max_subtract;
  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_ready, o_valid, o_last;
  logic [15:0] o_data, o_max;

  softmax_max_subtract dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_max(o_max)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0][15:0] d;
    logic [15:0]       mx;
    logic              gaps;
    logic              junk;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  int valid_cnt = 0, last_cnt = 0, run = 0, busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] m);
    int e;
    e = int'($signed(x)) - int'($signed(m));
    if (e < -32768) e = -32768;
    return 16'(e);
  endfunction

  always @(negedge clk) begin
    if (i_rst) begin
      run = 0;
      busy = 0;
    end else begin
      if (o_valid) begin
        valid_cnt++;
        run++;
        if (o_last) last_cnt++;
        if (q.size() == 0) chk("unexpected_output", {15'd0, o_last, o_data}, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("o_data", {16'd0, o_data}, {16'd0, e.d});
          chk("o_last", {31'd0, o_last}, {31'd0, e.l});
        end
      end else if (run > 0) begin
        chk("burst_len", run, 32);
        run = 0;
      end
      if (!o_ready) busy++;
      else if (busy > 0) begin
        chk("ready_low_cycles", busy, 32);
        busy = 0;
      end
    end
  end

  task automatic send(input vec_t v);
    int k = 0;
    while (k < 32) begin
      @(negedge clk);
      if (!o_ready) begin
        i_valid = v.junk;
        i_data  = 16'h7FFF;
      end else if (v.gaps && $urandom_range(0, 2) == 0) begin
        i_valid = 1'b0;
        i_data  = 16'h7FFF;
      end else begin
        i_valid = 1'b1;
        i_data  = v.d[k];
        if (k == 0)
          for (int j = 0; j < 32; j++) q.push_back({model(v.d[j], v.mx), j == 31});
        k++;
      end
    end
    @(negedge clk);
    i_valid = v.junk;
    i_data  = 16'h7FFF;
    chk("o_max", {16'd0, o_max}, {16'd0, v.mx});
    chk("latency_not_early", {31'd0, o_valid}, 32'd0);
    chk("ready_in_emit", {31'd0, o_ready}, 32'd0);
    @(negedge clk);
    chk("latency_first_out", {31'd0, o_valid}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 200, 1);
    repeat (2) @(negedge clk);
  endtask

  vec_t tbl[4];
  vec_t flat;

  initial begin
    for (int k = 0; k < 32; k++) begin
      tbl[0].d[k] = 16'(k * 256);
      tbl[1].d[k] = 16'((31 - k) * 256);
      tbl[2].d[k] = (k == 17) ? 16'h7FFF : 16'h8000;
      tbl[3].d[k] = 16'(k * 256);
      flat.d[k]   = 16'h0400;
    end
    tbl[0].mx = 16'h1F00; tbl[0].gaps = 1'b0; tbl[0].junk = 1'b0;
    tbl[1].mx = 16'h1F00; tbl[1].gaps = 1'b0; tbl[1].junk = 1'b1;
    tbl[2].mx = 16'h7FFF; tbl[2].gaps = 1'b0; tbl[2].junk = 1'b1;
    tbl[3].mx = 16'h1F00; tbl[3].gaps = 1'b1; tbl[3].junk = 1'b0;
    flat.mx = 16'h0400; flat.gaps = 1'b0; flat.junk = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_last", {31'd0, o_last}, 32'd0);
    chk("rst_o_data", {16'd0, o_data}, 32'd0);
    chk("rst_o_max", {16'd0, o_max}, 32'd0);
    chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
    i_rst = 1'b0;

    for (int i = 0; i < 4; i++) send(tbl[i]);
    i_valid = 1'b0;
    drain();

    send(tbl[0]);
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
    i_rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_data", {16'd0, o_data}, 32'd0);
    chk("async_rst_max", {16'd0, o_max}, 32'd0);
    chk("async_rst_ready", {31'd0, o_ready}, 32'd1);
    q.delete();
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    send(flat);
    i_valid = 1'b0;
    drain();

    chk("total_valid", valid_cnt, 5 * 32 + 9);
    chk("total_last", last_cnt, 5);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
